// File: rtl/minisrc_alu_pkg.sv
// ============================================================================
// Module : minisrc_alu_pkg
// Brief  : Shared widths and 4-bit ALU operation codes for the MiniSRC datapath
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package minisrc_alu_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 4;
   localparam int ALU_OP_W   = 4;
   localparam int NUM_REGS   = 16;

   localparam logic [ALU_OP_W-1:0] CTRL_ALU_ADD = 4'd0;
   localparam logic [ALU_OP_W-1:0] CTRL_ALU_SUB = 4'd1;
   localparam logic [ALU_OP_W-1:0] CTRL_ALU_AND = 4'd2;
   localparam logic [ALU_OP_W-1:0] CTRL_ALU_OR  = 4'd3;
   localparam logic [ALU_OP_W-1:0] CTRL_ALU_SHR = 4'd4;
   localparam logic [ALU_OP_W-1:0] CTRL_ALU_SRA = 4'd5;
   localparam logic [ALU_OP_W-1:0] CTRL_ALU_SHL = 4'd6;
   localparam logic [ALU_OP_W-1:0] CTRL_ALU_ROR = 4'd7;
   localparam logic [ALU_OP_W-1:0] CTRL_ALU_ROL = 4'd8;
   localparam logic [ALU_OP_W-1:0] CTRL_ALU_MUL = 4'd9;
   localparam logic [ALU_OP_W-1:0] CTRL_ALU_DIV = 4'd10;
   localparam logic [ALU_OP_W-1:0] CTRL_ALU_NEG = 4'd11;
   localparam logic [ALU_OP_W-1:0] CTRL_ALU_NOT = 4'd12;

endpackage

`default_nettype wire

// File: rtl/minisrc_datapath_if.sv
// ============================================================================
// Module : minisrc_datapath_if
// Brief  : Control/memory bundle between the MiniSRC control unit (master)
//          and the datapath (slave)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface minisrc_datapath_if;

   logic [31:0] iMemData;
   logic [31:0] oMemAddr;
   logic [31:0] oMemData;
   logic        iPC_nRst;
   logic        iPC_en;
   logic        iPC_jmp;
   logic        iPC_loadRA;
   logic        iPC_loadImm;
   logic        iRF_Write;
   logic [3:0]  iRF_AddrA;
   logic [3:0]  iRF_AddrB;
   logic [3:0]  iRF_AddrC;
   logic        iRWB_en;
   logic [3:0]  iALU_Ctrl;
   logic        iRA_en;
   logic        iRB_en;
   logic        iRZH_en;
   logic        iRZL_en;
   logic        iRAS_en;
   logic        oJ_zero;
   logic        oJ_nZero;
   logic        oJ_pos;
   logic        oJ_neg;
   logic        oALU_neg;
   logic        oALU_zero;
   logic        iMUX_BIS;
   logic        iMUX_RZHS;
   logic        iMUX_WBM;
   logic        iMUX_WBP;
   logic        iMUX_MAP;
   logic        iMUX_ASS;
   logic [31:0] iImm32;

   modport master (
      output iMemData, iPC_nRst, iPC_en, iPC_jmp, iPC_loadRA, iPC_loadImm,
             iRF_Write, iRF_AddrA, iRF_AddrB, iRF_AddrC, iRWB_en, iALU_Ctrl,
             iRA_en, iRB_en, iRZH_en, iRZL_en, iRAS_en,
             iMUX_BIS, iMUX_RZHS, iMUX_WBM, iMUX_WBP, iMUX_MAP, iMUX_ASS, iImm32,
      input  oMemAddr, oMemData, oJ_zero, oJ_nZero, oJ_pos, oJ_neg,
             oALU_neg, oALU_zero
   );

   modport slave (
      input  iMemData, iPC_nRst, iPC_en, iPC_jmp, iPC_loadRA, iPC_loadImm,
             iRF_Write, iRF_AddrA, iRF_AddrB, iRF_AddrC, iRWB_en, iALU_Ctrl,
             iRA_en, iRB_en, iRZH_en, iRZL_en, iRAS_en,
             iMUX_BIS, iMUX_RZHS, iMUX_WBM, iMUX_WBP, iMUX_MAP, iMUX_ASS, iImm32,
      output oMemAddr, oMemData, oJ_zero, oJ_nZero, oJ_pos, oJ_neg,
             oALU_neg, oALU_zero
   );

endinterface

`default_nettype wire

// File: rtl/minisrc_alu.sv
// ============================================================================
// Module : minisrc_alu
// Brief  : Combinational MiniSRC ALU, (A, B, op) -> {hi, lo}
//          Optional feature macro: DATAPATH_MULDIV_EN (signed MUL / DIV)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module minisrc_alu
   import minisrc_alu_pkg::*;
(
   input  logic [DATA_W-1:0]   a_i,
   input  logic [DATA_W-1:0]   b_i,
   input  logic [ALU_OP_W-1:0] op_i,
   output logic [DATA_W-1:0]   hi_o,
   output logic [DATA_W-1:0]   lo_o
);

   logic [4:0] sh;
   assign sh = b_i[4:0];

`ifdef DATAPATH_MULDIV_EN
   // Sign-extend to 64 bits first so the truncated product is the full signed result.
   logic [63:0] prod;
   assign prod = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
`endif

   // Operation select; hi stays zero except for the wide MUL/DIV results.
   always_comb begin
      hi_o = '0;
      lo_o = '0;
      case (op_i)
         CTRL_ALU_ADD: lo_o = a_i + b_i;
         CTRL_ALU_SUB: lo_o = a_i - b_i;
         CTRL_ALU_AND: lo_o = a_i & b_i;
         CTRL_ALU_OR:  lo_o = a_i | b_i;
         CTRL_ALU_SHR: lo_o = a_i >> sh;
         CTRL_ALU_SRA: lo_o = $unsigned($signed(a_i) >>> sh);
         CTRL_ALU_SHL: lo_o = a_i << sh;
         // A shift by 32 yields zero, so sh==0 degenerates cleanly to a_i.
         CTRL_ALU_ROR: lo_o = (a_i >> sh) | (a_i << (6'd32 - {1'b0, sh}));
         CTRL_ALU_ROL: lo_o = (a_i << sh) | (a_i >> (6'd32 - {1'b0, sh}));
`ifdef DATAPATH_MULDIV_EN
         CTRL_ALU_MUL: begin
            hi_o = prod[63:32];
            lo_o = prod[31:0];
         end
         CTRL_ALU_DIV: begin
            if (b_i == '0) begin
               lo_o = '1;
               hi_o = a_i;
            end else begin
               lo_o = $unsigned($signed(a_i) / $signed(b_i));
               hi_o = $unsigned($signed(a_i) % $signed(b_i));
            end
         end
`endif
         CTRL_ALU_NEG: lo_o = '0 - b_i;
         CTRL_ALU_NOT: lo_o = ~b_i;
         default: begin
            hi_o = '0;
            lo_o = '0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/minisrc_datapath.sv
// ============================================================================
// Module : minisrc_datapath
// Brief  : MiniSRC 32-bit datapath - PC, 16x32 register file, ALU latches,
//          write-back register, memory address/data paths. All control comes
//          from the interface. Optional feature macro: DATAPATH_MULDIV_EN
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module minisrc_datapath
   import minisrc_alu_pkg::*;
(
   input  logic              iClk,
   input  logic              nRst,
   minisrc_datapath_if.slave bus
);

   logic [DATA_W-1:0] rf_q [NUM_REGS];
   logic [DATA_W-1:0] ra_q,  ra_d;
   logic [DATA_W-1:0] rb_q,  rb_d;
   logic [DATA_W-1:0] rzh_q, rzh_d;
   logic [DATA_W-1:0] rzl_q, rzl_d;
   logic [DATA_W-1:0] ras_q, ras_d;
   logic [DATA_W-1:0] rwb_q, rwb_d;
   logic [DATA_W-1:0] pc_q,  pc_d;

   logic [DATA_W-1:0] rf_a, rf_b, alu_hi, alu_lo, rz, wb;

   assign rf_a = rf_q[bus.iRF_AddrA];
   assign rf_b = rf_q[bus.iRF_AddrB];

   minisrc_alu u_alu (
      .a_i  (ra_q),
      .b_i  (rb_q),
      .op_i (bus.iALU_Ctrl),
      .hi_o (alu_hi),
      .lo_o (alu_lo)
   );

   assign rz = bus.iMUX_RZHS ? rzh_q : rzl_q;

   // Write-back source, memory data wins over PC, which wins over RAS.
   always_comb begin
      wb = rz;
      if (bus.iMUX_WBM)      wb = bus.iMemData;
      else if (bus.iMUX_WBP) wb = pc_q;
      else if (bus.iMUX_ASS) wb = ras_q;
   end

   // Next values for the operand, result and write-back latches.
   always_comb begin
      ra_d  = bus.iRA_en  ? rf_a : ra_q;
      rb_d  = bus.iRB_en  ? (bus.iMUX_BIS ? bus.iImm32 : rf_b) : rb_q;
      rzh_d = bus.iRZH_en ? alu_hi : rzh_q;
      rzl_d = bus.iRZL_en ? alu_lo : rzl_q;
      ras_d = bus.iRAS_en ? rz : ras_q;
      rwb_d = bus.iRWB_en ? wb : rwb_q;
   end

   // PC next value; the synchronous clear overrides every update source.
   always_comb begin
      pc_d = pc_q;
      if (!bus.iPC_nRst) begin
         pc_d = '0;
      end else if (bus.iPC_en) begin
         if (bus.iPC_loadRA)                       pc_d = ra_q;
         else if (bus.iPC_loadImm && bus.iPC_jmp)  pc_d = pc_q + bus.iImm32;
         else                                      pc_d = pc_q + 32'd1;
      end
   end

   // Datapath registers.
   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         ra_q  <= '0;
         rb_q  <= '0;
         rzh_q <= '0;
         rzl_q <= '0;
         ras_q <= '0;
         rwb_q <= '0;
         pc_q  <= '0;
      end else begin
         ra_q  <= ra_d;
         rb_q  <= rb_d;
         rzh_q <= rzh_d;
         rzl_q <= rzl_d;
         ras_q <= ras_d;
         rwb_q <= rwb_d;
         pc_q  <= pc_d;
      end
   end

   // Register file write port; R0 is an ordinary register.
   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      end else if (bus.iRF_Write) begin
         rf_q[bus.iRF_AddrC] <= rwb_q;
      end
   end

   assign bus.oMemAddr  = bus.iMUX_MAP ? pc_q : ras_q;
   assign bus.oMemData  = rf_b;
   assign bus.oJ_zero   = (ra_q == '0);
   assign bus.oJ_nZero  = (ra_q != '0);
   assign bus.oJ_pos    = ~ra_q[31];
   assign bus.oJ_neg    = ra_q[31];
   assign bus.oALU_zero = (alu_lo == '0);
   assign bus.oALU_neg  = alu_lo[31];

endmodule

`default_nettype wire

// File: tb/tb_minisrc_datapath.sv
// ============================================================================
// Module : tb_minisrc_datapath
// Brief  : Self-checking bench for minisrc_datapath; a register-transfer
//          model checked every falling edge plus hand-computed literal checks
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_minisrc_datapath;

   logic iClk = 1'b0;
   logic nRst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   minisrc_datapath_if bus ();

   minisrc_datapath dut (
      .iClk (iClk),
      .nRst (nRst),
      .bus  (bus)
   );

   always #5 iClk = ~iClk;

   // ---------------- behavioural model ----------------
   logic [31:0] m_rf [16];
   logic [31:0] m_ra, m_rb, m_rzh, m_rzl, m_ras, m_rwb, m_pc;

   function automatic logic [63:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
      logic [31:0] lo, hi, t;
      int          s;
      longint      p;
      lo = 0; hi = 0; t = a; s = int'(b[4:0]);
      case (op)
         4'd0:  lo = a + b;
         4'd1:  lo = a - b;
         4'd2:  lo = a & b;
         4'd3:  lo = a | b;
         4'd4:  lo = a >> s;
         4'd5:  begin for (int i = 0; i < s; i++) t = {t[31], t[31:1]}; lo = t; end
         4'd6:  lo = a << s;
         4'd7:  begin for (int i = 0; i < s; i++) t = {t[0], t[31:1]}; lo = t; end
         4'd8:  begin for (int i = 0; i < s; i++) t = {t[30:0], t[31]}; lo = t; end
`ifdef DATAPATH_MULDIV_EN
         4'd9:  begin p = longint'(int'(a)) * longint'(int'(b)); hi = p[63:32]; lo = p[31:0]; end
         4'd10: begin
            if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
            else begin lo = int'(a) / int'(b); hi = int'(a) % int'(b); end
         end
`endif
         4'd11: lo = 32'd0 - b;
         4'd12: lo = ~b;
         default: lo = 0;
      endcase
      return {hi, lo};
   endfunction

   function automatic logic [31:0] m_hi();
      logic [63:0] r;
      r = model_alu(m_ra, m_rb, bus.iALU_Ctrl);
      return r[63:32];
   endfunction

   function automatic logic [31:0] m_lo();
      logic [63:0] r;
      r = model_alu(m_ra, m_rb, bus.iALU_Ctrl);
      return r[31:0];
   endfunction

   function automatic logic [31:0] m_rz();
      return bus.iMUX_RZHS ? m_rzh : m_rzl;
   endfunction

   function automatic logic [31:0] m_wb();
      if (bus.iMUX_WBM) return bus.iMemData;
      if (bus.iMUX_WBP) return m_pc;
      if (bus.iMUX_ASS) return m_ras;
      return m_rz();
   endfunction

   function automatic logic [31:0] m_pc_next();
      if (!bus.iPC_nRst) return 32'd0;
      if (!bus.iPC_en) return m_pc;
      if (bus.iPC_loadRA) return m_ra;
      if (bus.iPC_loadImm && bus.iPC_jmp) return m_pc + bus.iImm32;
      return m_pc + 32'd1;
   endfunction

   always @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         for (int i = 0; i < 16; i++) m_rf[i] <= 0;
         m_ra <= 0; m_rb <= 0; m_rzh <= 0; m_rzl <= 0;
         m_ras <= 0; m_rwb <= 0; m_pc <= 0;
      end else begin
         if (bus.iRF_Write) m_rf[bus.iRF_AddrC] <= m_rwb;
         if (bus.iRA_en)    m_ra  <= m_rf[bus.iRF_AddrA];
         if (bus.iRB_en)    m_rb  <= bus.iMUX_BIS ? bus.iImm32 : m_rf[bus.iRF_AddrB];
         if (bus.iRZH_en)   m_rzh <= m_hi();
         if (bus.iRZL_en)   m_rzl <= m_lo();
         if (bus.iRAS_en)   m_ras <= m_rz();
         if (bus.iRWB_en)   m_rwb <= m_wb();
         m_pc <= m_pc_next();
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [31:0] lo;
      lo = m_lo();
      check("model_memaddr", bus.oMemAddr, bus.iMUX_MAP ? m_pc : m_ras);
      check("model_memdata", bus.oMemData, m_rf[bus.iRF_AddrB]);
      check("model_jflags", {28'd0, bus.oJ_zero, bus.oJ_nZero, bus.oJ_pos, bus.oJ_neg},
            {28'd0, m_ra == 0, m_ra != 0, ~m_ra[31], m_ra[31]});
      check("model_aluflags", {30'd0, bus.oALU_zero, bus.oALU_neg}, {30'd0, lo == 0, lo[31]});
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge iClk);
         compare_all();
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic idle();
      bus.iPC_nRst = 1'b1; bus.iPC_en = 1'b0; bus.iPC_jmp = 1'b0;
      bus.iPC_loadRA = 1'b0; bus.iPC_loadImm = 1'b0;
      bus.iRF_Write = 1'b0; bus.iRWB_en = 1'b0;
      bus.iRA_en = 1'b0; bus.iRB_en = 1'b0; bus.iRZH_en = 1'b0;
      bus.iRZL_en = 1'b0; bus.iRAS_en = 1'b0;
      bus.iMUX_BIS = 1'b0; bus.iMUX_RZHS = 1'b0; bus.iMUX_WBM = 1'b0;
      bus.iMUX_WBP = 1'b0; bus.iMUX_MAP = 1'b0; bus.iMUX_ASS = 1'b0;
   endtask

   task automatic load_reg(input logic [3:0] r, input logic [31:0] v);
      idle(); bus.iMemData = v; bus.iMUX_WBM = 1'b1; bus.iRWB_en = 1'b1; tick();
      idle(); bus.iRF_Write = 1'b1; bus.iRF_AddrC = r; tick();
      idle();
   endtask

   // RA <- RF[ra], RB <- imm, then latch ALU result; RAS takes lo then hi.
   task automatic alu_run(input logic [3:0] ra, input logic [31:0] imm, input logic [3:0] op);
      idle(); bus.iRF_AddrA = ra; bus.iRA_en = 1'b1; bus.iRB_en = 1'b1;
      bus.iMUX_BIS = 1'b1; bus.iImm32 = imm; bus.iALU_Ctrl = op; tick();
      idle(); bus.iRZH_en = 1'b1; bus.iRZL_en = 1'b1; tick();
      idle(); bus.iRAS_en = 1'b1; tick();
      idle(); bus.iRAS_en = 1'b1; bus.iMUX_RZHS = 1'b1; bus.iRWB_en = 1'b1; bus.iMUX_ASS = 1'b1; tick();
      idle(); bus.iRF_Write = 1'b1; bus.iRF_AddrC = 4'd11; bus.iRF_AddrB = 4'd11; tick();
      idle();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [31:0] imms [3];
      logic [3:0]  srcs [3];
      imms[0] = 32'd5; imms[1] = 32'hFFFF_FFF0; imms[2] = 32'h0000_0021;
      srcs[0] = 4'd9;  srcs[1] = 4'd10;        srcs[2] = 4'd3;

      idle();
      bus.iMemData = 0; bus.iImm32 = 0; bus.iALU_Ctrl = 0;
      bus.iRF_AddrA = 0; bus.iRF_AddrB = 0; bus.iRF_AddrC = 0;
      nRst = 1'b0;
      tick();
      fork compare_loop(); join_none
      tick();

      // Reset state
      check("rst_memaddr", bus.oMemAddr, 32'd0);
      check("rst_memdata", bus.oMemData, 32'd0);
      check("rst_jzero", {31'd0, bus.oJ_zero}, 32'd1);
      check("rst_jpos", {31'd0, bus.oJ_pos}, 32'd1);
      check("rst_aluzero", {31'd0, bus.oALU_zero}, 32'd1);
      nRst = 1'b1;
      tick();

      // Loads through the write-back path
      load_reg(4'd3, 32'h22);
      load_reg(4'd7, 32'h24);
      load_reg(4'd4, 32'h28);
      bus.iRF_AddrB = 4'd4; #1;
      check("load_r4", bus.oMemData, 32'h28);

      // SRA R3 by R7 -> R4
      idle(); bus.iRF_AddrA = 4'd3; bus.iRF_AddrB = 4'd7; bus.iRA_en = 1'b1; bus.iRB_en = 1'b1; tick();
      idle(); bus.iALU_Ctrl = 4'd5; bus.iRZH_en = 1'b1; bus.iRZL_en = 1'b1; tick();
      idle(); bus.iRWB_en = 1'b1; tick();
      idle(); bus.iRF_Write = 1'b1; bus.iRF_AddrC = 4'd4; bus.iRF_AddrB = 4'd4; #1;
      check("rf_same_cycle_old", bus.oMemData, 32'h28);
      tick();
      idle();
      check("sra_r4", bus.oMemData, 32'h2);

      // Fetch
      bus.iMUX_MAP = 1'b1; bus.iPC_en = 1'b1; bus.iPC_jmp = 1'b1; #1;
      check("fetch_addr0", bus.oMemAddr, 32'd0);
      tick();
      check("fetch_pc1", bus.oMemAddr, 32'd1);
      bus.iPC_jmp = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("pc5", bus.oMemAddr, 32'd5);

      // Branch with RA = 0
      idle(); bus.iMUX_MAP = 1'b1; bus.iRF_AddrA = 4'd0; bus.iRA_en = 1'b1; tick();
      check("ra0_jzero", {31'd0, bus.oJ_zero}, 32'd1);
      idle(); bus.iMUX_MAP = 1'b1; bus.iPC_en = 1'b1; bus.iPC_jmp = 1'b1; bus.iPC_loadImm = 1'b1;
      bus.iImm32 = 32'hFFFF_FFFF; tick();
      check("branch_pc4", bus.oMemAddr, 32'd4);
      bus.iPC_jmp = 1'b0; tick();
      check("notaken_pc5", bus.oMemAddr, 32'd5);
      idle(); bus.iMUX_MAP = 1'b1; bus.iRF_AddrA = 4'd3; bus.iRA_en = 1'b1; tick();
      bus.iRA_en = 1'b0; bus.iPC_en = 1'b1; bus.iPC_loadRA = 1'b1; tick();
      check("loadra_pc", bus.oMemAddr, 32'h22);
      bus.iPC_loadRA = 1'b0; bus.iPC_nRst = 1'b0; tick();
      check("pc_sync_clear", bus.oMemAddr, 32'd0);
      bus.iPC_nRst = 1'b1; bus.iPC_jmp = 1'b1; bus.iPC_loadImm = 1'b1; bus.iImm32 = 32'hFFFF_FFFF; tick();
      check("pc_wrap_neg", bus.oMemAddr, 32'hFFFF_FFFF);
      bus.iPC_loadImm = 1'b0; tick();
      check("pc_wrap_zero", bus.oMemAddr, 32'd0);
      tick();

      // PC into write-back; memory data has priority over PC
      idle(); bus.iRWB_en = 1'b1; bus.iMUX_WBP = 1'b1; tick();
      idle(); bus.iRF_Write = 1'b1; bus.iRF_AddrC = 4'd12; bus.iRF_AddrB = 4'd12; tick();
      check("wbp_r12", bus.oMemData, 32'd1);
      idle(); bus.iRWB_en = 1'b1; bus.iMUX_WBM = 1'b1; bus.iMUX_WBP = 1'b1; bus.iMemData = 32'h55; tick();
      idle(); bus.iRF_Write = 1'b1; bus.iRF_AddrC = 4'd13; bus.iRF_AddrB = 4'd13; tick();
      check("wbm_prio_r13", bus.oMemData, 32'h55);

      // Negative RA
      load_reg(4'd5, 32'h8000_0000);
      bus.iRF_AddrA = 4'd5; bus.iRA_en = 1'b1; tick();
      check("jneg", {30'd0, bus.oJ_neg, bus.oJ_zero}, 32'b10);

      // MUL and DIV-by-zero
      load_reg(4'd6, 32'h0001_0000);
      load_reg(4'd8, 32'd7);
      alu_run(4'd6, 32'h0001_0000, 4'd9);
`ifdef DATAPATH_MULDIV_EN
      check("mul_hi", bus.oMemAddr, 32'd1);
`else
      check("mul_hi_off", bus.oMemAddr, 32'd0);
`endif
      check("mul_lo", bus.oMemData, 32'd0);
      alu_run(4'd8, 32'd0, 4'd10);
`ifdef DATAPATH_MULDIV_EN
      check("div0_hi", bus.oMemAddr, 32'd7);
      check("div0_lo", bus.oMemData, 32'hFFFF_FFFF);
`else
      check("div0_hi_off", bus.oMemAddr, 32'd0);
      check("div0_lo_off", bus.oMemData, 32'd0);
`endif
      alu_run(4'd3, 32'd5, 4'd1);
      check("sub_lo", bus.oMemData, 32'h1D);

      // Sweep every op over a few operand pairs; the model checks each cycle
      load_reg(4'd9, 32'hF000_00F3);
      load_reg(4'd10, 32'h1234_5678);
      for (int p = 0; p < 3; p++)
         for (int op = 0; op < 16; op++)
            alu_run(srcs[p], imms[p], 4'(op));

      // Asynchronous reset between edges
      load_reg(4'd4, 32'h99);
      bus.iMUX_MAP = 1'b1; bus.iPC_en = 1'b1; bus.iRF_AddrA = 4'd4; bus.iRA_en = 1'b1;
      bus.iRF_AddrB = 4'd4; tick(); tick();
      #2 nRst = 1'b0;
      #1;
      check("arst_pc", bus.oMemAddr, 32'd0);
      check("arst_rf", bus.oMemData, 32'd0);
      check("arst_ra", {31'd0, bus.oJ_zero}, 32'd1);
      bus.iMUX_MAP = 1'b0; #1;
      check("arst_ras", bus.oMemAddr, 32'd0);
      tick();
      nRst = 1'b1;
      idle();
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
